// File: rtl/mesh_traffic_sequencer.sv
// mesh_traffic_sequencer: walks every (source, destination) node pair of an
// X x Y mesh in index order, injects one addressed flit per pair and checks
// that the monitored destination returns it intact within a bounded wait.
module mesh_traffic_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int X_DIMENSION = 4,
  parameter int Y_DIMENSION = 4,
  parameter int X_DIM_W     = (X_DIMENSION > 1) ? $clog2(X_DIMENSION) : 1,
  parameter int Y_DIM_W     = (Y_DIMENSION > 1) ? $clog2(Y_DIMENSION) : 1,
  parameter int TIMEOUT     = 256,
  parameter int SKIP_SELF   = 1
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           err_cnt_o,
  output logic [15:0]           to_cnt_o,
  output logic [15:0]           pair_cnt_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [X_DIM_W-1:0]    source_x_o,
  output logic [Y_DIM_W-1:0]    source_y_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [X_DIM_W-1:0]    monitor_x_o,
  output logic [Y_DIM_W-1:0]    monitor_y_o
);

  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PAY_W = DATA_WIDTH - X_DIM_W - Y_DIM_W;
  localparam logic [X_DIM_W-1:0] X_LAST  = X_DIM_W'(X_DIMENSION - 1);
  localparam logic [Y_DIM_W-1:0] Y_LAST  = Y_DIM_W'(Y_DIMENSION - 1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [Y_DIM_W-1:0] y;
    logic [X_DIM_W-1:0] x;
  } node_t;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SEND, S_WAIT, S_NEXT, S_DONE
  } state_t;

  // Next node in index order: x first, carry into y, wrap after the last node.
  function automatic node_t node_inc(input node_t n);
    node_t r;
    r = n;
    if (n.x == X_LAST) begin
      r.x = '0;
      r.y = (n.y == Y_LAST) ? '0 : n.y + 1'b1;
    end else begin
      r.x = n.x + 1'b1;
    end
    return r;
  endfunction

  function automatic logic node_last(input node_t n);
    return (n.x == X_LAST) && (n.y == Y_LAST);
  endfunction

  state_t                r_state, w_state_nxt;
  node_t                 r_src, r_dst;
  node_t                 w_dst_inc, w_src_adv, w_dst_adv, w_first_dst;
  logic                  w_last_pair, w_arrive, w_timeout, w_mismatch;
  logic [TO_W-1:0]       r_to_tmr;
  logic [15:0]           r_err_cnt, r_to_cnt, r_pair_cnt;
  logic [DATA_WIDTH-1:0] w_flit;
  logic                  w_start;

  assign w_start = (r_state == S_IDLE) && start_i;

  // Pair stepping: destination is the inner loop; when self-pairs are skipped
  // a destination that lands on the (possibly new) source is stepped once more.
  always_comb begin
    w_dst_inc   = node_inc(r_dst);
    w_src_adv   = node_last(r_dst) ? node_inc(r_src) : r_src;
    w_dst_adv   = ((SKIP_SELF != 0) && (w_dst_inc == w_src_adv)) ? node_inc(w_dst_inc) : w_dst_inc;
    w_last_pair = node_last(r_src) &&
                  (node_last(r_dst) || ((SKIP_SELF != 0) && (w_dst_inc == r_src)));
    w_first_dst = (SKIP_SELF != 0) ? node_inc(node_t'('0)) : node_t'('0);
  end

  // Flit carries destination coordinates in the low bits and the pair number
  // above; it only depends on state that is frozen from SETUP through WAIT,
  // so the same value serves for injection and for the return check.
  assign w_flit     = {PAY_W'(r_pair_cnt), r_dst.y, r_dst.x};
  assign w_arrive   = (r_state == S_WAIT) && valid_i;
  assign w_timeout  = (r_state == S_WAIT) && !valid_i && (r_to_tmr == TO_LAST);
  assign w_mismatch = w_arrive && (data_i != w_flit);

  // State register.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy_o      = (r_state != S_IDLE);
    done_o      = 1'b0;
    valid_o     = 1'b0;
    ready_o     = 1'b0;
    data_o      = '0;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_SETUP;
      S_SETUP: w_state_nxt = S_SEND;
      S_SEND: begin
        valid_o = 1'b1;
        data_o  = w_flit;
        if (ready_i) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        ready_o = 1'b1;
        if (w_arrive || w_timeout) w_state_nxt = S_NEXT;
      end
      S_NEXT:  w_state_nxt = w_last_pair ? S_DONE : S_SETUP;
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Current pair: loaded with the first pair on start, advanced leaving NEXT.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_src <= '0;
      r_dst <= '0;
    end else if (w_start) begin
      r_src <= '0;
      r_dst <= w_first_dst;
    end else if ((r_state == S_NEXT) && !w_last_pair) begin
      r_src <= w_src_adv;
      r_dst <= w_dst_adv;
    end
  end

  // Wait timer: zero outside WAIT, so it is cleared on every WAIT entry.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)                r_to_tmr <= '0;
    else if (r_state == S_WAIT)  r_to_tmr <= r_to_tmr + 1'b1;
    else                         r_to_tmr <= '0;
  end

  // Saturating result counters, cleared when a run starts and held after it.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_err_cnt  <= '0;
      r_to_cnt   <= '0;
      r_pair_cnt <= '0;
    end else if (w_start) begin
      r_err_cnt  <= '0;
      r_to_cnt   <= '0;
      r_pair_cnt <= '0;
    end else begin
      if ((w_mismatch || w_timeout) && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
      if (w_timeout && (r_to_cnt != 16'hFFFF))                  r_to_cnt  <= r_to_cnt + 16'd1;
      if ((r_state == S_NEXT) && (r_pair_cnt != 16'hFFFF))      r_pair_cnt <= r_pair_cnt + 16'd1;
    end
  end

  assign err_cnt_o   = r_err_cnt;
  assign to_cnt_o    = r_to_cnt;
  assign pair_cnt_o  = r_pair_cnt;
  assign source_x_o  = r_src.x;
  assign source_y_o  = r_src.y;
  assign monitor_x_o = r_dst.x;
  assign monitor_y_o = r_dst.y;

endmodule

// File: tb/tb_mesh_traffic_sequencer.sv
// Bench for mesh_traffic_sequencer on a 2x2 mesh: instance A skips self-pairs
// with a short timeout, instance B visits all 16 pairs. Each instance has a
// loopback node that echoes the injected flit; expected pairs are queued from
// an index-order model and checked at every injection handshake.
module tb_mesh_traffic_sequencer;

  typedef struct packed {
    logic        sy;
    logic        sx;
    logic        dy;
    logic        dx;
    logic [31:0] flit;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_start = 0, a_ready_i = 1, a_valid_i = 0;
  logic [31:0] a_data_i = '0;
  logic        a_busy_o, a_done_o, a_valid_o, a_ready_o;
  logic [15:0] a_err_o, a_to_o, a_pair_o;
  logic [31:0] a_data_o;
  logic        a_sx, a_sy, a_mx, a_my;

  // Instance B signals
  logic        b_start = 0, b_ready_i = 1, b_valid_i = 0;
  logic [31:0] b_data_i = '0;
  logic        b_busy_o, b_done_o, b_valid_o, b_ready_o;
  logic [15:0] b_err_o, b_to_o, b_pair_o;
  logic [31:0] b_data_o;
  logic        b_sx, b_sy, b_mx, b_my;

  mesh_traffic_sequencer #(
    .DATA_WIDTH(32), .X_DIMENSION(2), .Y_DIMENSION(2), .TIMEOUT(8), .SKIP_SELF(1)
  ) dut_a (
    .clk_i(clk), .arstn_i(rst_n), .start_i(a_start), .busy_o(a_busy_o), .done_o(a_done_o),
    .err_cnt_o(a_err_o), .to_cnt_o(a_to_o), .pair_cnt_o(a_pair_o),
    .data_o(a_data_o), .valid_o(a_valid_o), .ready_i(a_ready_i),
    .source_x_o(a_sx), .source_y_o(a_sy),
    .data_i(a_data_i), .valid_i(a_valid_i), .ready_o(a_ready_o),
    .monitor_x_o(a_mx), .monitor_y_o(a_my)
  );

  mesh_traffic_sequencer #(
    .DATA_WIDTH(32), .X_DIMENSION(2), .Y_DIMENSION(2), .TIMEOUT(16), .SKIP_SELF(0)
  ) dut_b (
    .clk_i(clk), .arstn_i(rst_n), .start_i(b_start), .busy_o(b_busy_o), .done_o(b_done_o),
    .err_cnt_o(b_err_o), .to_cnt_o(b_to_o), .pair_cnt_o(b_pair_o),
    .data_o(b_data_o), .valid_o(b_valid_o), .ready_i(b_ready_i),
    .source_x_o(b_sx), .source_y_o(b_sy),
    .data_i(b_data_i), .valid_i(b_valid_i), .ready_o(b_ready_o),
    .monitor_x_o(b_mx), .monitor_y_o(b_my)
  );

  int errors = 0;
  int checks = 0;

  exp_t a_q[$];
  exp_t b_q[$];
  exp_t a_e, b_e;
  int   a_sent = 0, b_sent = 0;
  int   a_drop = -1, a_corrupt = -1;
  int   a_done_cnt = 0;
  int   a_wlen[16];
  logic a_pend = 0, b_pend = 0;
  logic [31:0] a_echo = '0, b_echo = '0;

  // Reference model of one expected pair on a 2x2 mesh (index = y*2 + x).
  function automatic exp_t mk(input int s, input int d, input int idx);
    exp_t e;
    e.sx   = 1'(s % 2);
    e.sy   = 1'(s / 2);
    e.dx   = 1'(d % 2);
    e.dy   = 1'(d / 2);
    e.flit = 32'(idx * 4 + (d / 2) * 2 + (d % 2));
    return e;
  endfunction

  task automatic fill_a();
    int idx;
    idx = 0;
    a_q.delete();
    for (int s = 0; s < 4; s++)
      for (int d = 0; d < 4; d++)
        if (s != d) begin
          a_q.push_back(mk(s, d, idx));
          idx++;
        end
  endtask

  task automatic fill_b();
    int idx;
    idx = 0;
    b_q.delete();
    for (int s = 0; s < 4; s++)
      for (int d = 0; d < 4; d++) begin
        b_q.push_back(mk(s, d, idx));
        idx++;
      end
  endtask

  // Loopback node A: checks each injected flit, echoes it in the first WAIT
  // cycle, optionally dropping or corrupting one chosen pair.
  always @(negedge clk) begin
    if (!rst_n) begin
      a_pend    = 1'b0;
      a_valid_i = 1'b0;
    end else begin
      if (a_done_o) a_done_cnt++;
      if (a_ready_o && a_sent > 0 && a_sent <= 16) a_wlen[a_sent-1]++;
      if (a_ready_o && a_pend) begin
        a_valid_i = 1'b1;
        a_data_i  = a_echo;
        a_pend    = 1'b0;
      end else begin
        a_valid_i = 1'b0;
      end
      if (a_valid_o && a_ready_i) begin
        checks++;
        if (a_q.size() == 0) begin
          errors++;
          $display("FAIL a_sb_empty: pair %0d injected data=%h, expected no more pairs", a_sent, a_data_o);
        end else begin
          a_e = a_q.pop_front();
          if ({a_sy, a_sx, a_my, a_mx, a_data_o} !== {a_e.sy, a_e.sx, a_e.dy, a_e.dx, a_e.flit}) begin
            errors++;
            $display("FAIL a_pair%0d: got src=(%0d,%0d) dst=(%0d,%0d) data=%h, expected src=(%0d,%0d) dst=(%0d,%0d) data=%h",
                     a_sent, a_sx, a_sy, a_mx, a_my, a_data_o, a_e.sx, a_e.sy, a_e.dx, a_e.dy, a_e.flit);
          end
        end
        a_echo = a_data_o ^ ((a_sent == a_corrupt) ? 32'h1 : 32'h0);
        a_pend = (a_sent != a_drop);
        a_sent++;
      end
    end
  end

  // Loopback node B: ideal echo plus scoreboard check.
  always @(negedge clk) begin
    if (!rst_n) begin
      b_pend    = 1'b0;
      b_valid_i = 1'b0;
    end else begin
      if (b_ready_o && b_pend) begin
        b_valid_i = 1'b1;
        b_data_i  = b_echo;
        b_pend    = 1'b0;
      end else begin
        b_valid_i = 1'b0;
      end
      if (b_valid_o && b_ready_i) begin
        checks++;
        if (b_q.size() == 0) begin
          errors++;
          $display("FAIL b_sb_empty: pair %0d injected data=%h, expected no more pairs", b_sent, b_data_o);
        end else begin
          b_e = b_q.pop_front();
          if ({b_sy, b_sx, b_my, b_mx, b_data_o} !== {b_e.sy, b_e.sx, b_e.dy, b_e.dx, b_e.flit}) begin
            errors++;
            $display("FAIL b_pair%0d: got src=(%0d,%0d) dst=(%0d,%0d) data=%h, expected src=(%0d,%0d) dst=(%0d,%0d) data=%h",
                     b_sent, b_sx, b_sy, b_mx, b_my, b_data_o, b_e.sx, b_e.sy, b_e.dx, b_e.dy, b_e.flit);
          end
        end
        b_echo = b_data_o;
        b_pend = 1'b1;
        b_sent++;
      end
    end
  end

  // Called at a negedge with A idle; leaves us at the SETUP-cycle negedge.
  task automatic start_a(input string tag);
    fill_a();
    a_sent     = 0;
    a_done_cnt = 0;
    foreach (a_wlen[i]) a_wlen[i] = 0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    checks++;
    if ({a_busy_o, a_pair_o, a_err_o, a_to_o, a_sx, a_sy, a_mx, a_my} !== {1'b1, 48'd0, 4'b0010}) begin
      errors++;
      $display("FAIL %s_start: busy=%b pair=%0d err=%0d to=%0d src=(%0d,%0d) dst=(%0d,%0d), expected busy=1 counters 0 src=(0,0) dst=(1,0)",
               tag, a_busy_o, a_pair_o, a_err_o, a_to_o, a_sx, a_sy, a_mx, a_my);
    end
  endtask

  task automatic wait_done_a(input string tag);
    int cyc;
    cyc = 0;
    while (a_done_o !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL %s_done: done_o=%b after %0d cycles, expected 1", tag, a_done_o, cyc);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_end_a(input string tag, input int pairs, input int errs, input int tos);
    checks++;
    if ({a_busy_o, a_pair_o, a_err_o, a_to_o} !== {1'b0, 16'(pairs), 16'(errs), 16'(tos)}) begin
      errors++;
      $display("FAIL %s_counts: busy=%b pair=%0d err=%0d to=%0d, expected busy=0 pair=%0d err=%0d to=%0d",
               tag, a_busy_o, a_pair_o, a_err_o, a_to_o, pairs, errs, tos);
    end
    checks++;
    if (a_done_cnt !== 1 || a_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_done_pulses: pulses=%0d unsent=%0d, expected pulses=1 unsent=0", tag, a_done_cnt, a_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_busy_o, a_done_o, a_valid_o, a_ready_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: busy/done/valid/ready=%b, expected 0000", {a_busy_o, a_done_o, a_valid_o, a_ready_o});
    end
    checks++;
    if ({a_err_o, a_to_o, a_pair_o} !== 48'd0) begin
      errors++;
      $display("FAIL reset_counters: err=%0d to=%0d pair=%0d, expected 0", a_err_o, a_to_o, a_pair_o);
    end
    checks++;
    if ({a_data_o, a_sx, a_sy, a_mx, a_my} !== 36'd0) begin
      errors++;
      $display("FAIL reset_data: data=%h coords=%b, expected 0", a_data_o, {a_sx, a_sy, a_mx, a_my});
    end
    checks++;
    if ({b_busy_o, b_valid_o, b_ready_o, b_pair_o, b_data_o} !== 51'd0) begin
      errors++;
      $display("FAIL reset_b: busy=%b valid=%b ready=%b pair=%0d data=%h, expected 0", b_busy_o, b_valid_o, b_ready_o, b_pair_o, b_data_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    start_a("loopback");
    repeat (6) @(negedge clk);
    a_start = 1'b1;           // must be ignored while busy
    @(negedge clk);
    a_start = 1'b0;
    wait_done_a("loopback");
    check_end_a("loopback", 12, 0, 0);
    checks++;
    if (a_wlen[0] !== 1) begin
      errors++;
      $display("FAIL loopback_wait: pair0 WAIT cycles=%0d, expected 1", a_wlen[0]);
    end
  endtask

  task automatic test_timeout();
    a_drop = 3;
    start_a("timeout");
    wait_done_a("timeout");
    a_drop = -1;
    check_end_a("timeout", 12, 1, 1);
    checks++;
    if (a_wlen[3] !== 8) begin
      errors++;
      $display("FAIL timeout_wait: pair3 WAIT cycles=%0d, expected 8", a_wlen[3]);
    end
  endtask

  task automatic test_corrupt();
    a_corrupt = 5;
    start_a("corrupt");
    wait_done_a("corrupt");
    a_corrupt = -1;
    check_end_a("corrupt", 12, 1, 0);
  endtask

  task automatic test_stall();
    logic [31:0] d0;
    int cyc;
    exp_t e0;
    e0 = mk(0, 1, 0);
    a_ready_i = 1'b0;
    start_a("stall");
    cyc = 0;
    while (a_valid_o !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    d0 = a_data_o;
    checks++;
    if (a_valid_o !== 1'b1 || d0 !== e0.flit) begin
      errors++;
      $display("FAIL stall_first: valid=%b data=%h, expected valid=1 data=%h", a_valid_o, d0, e0.flit);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({a_valid_o, a_ready_o, a_busy_o, a_data_o} !== {3'b101, e0.flit}) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b ready=%b busy=%b data=%h, expected valid=1 ready=0 busy=1 data=%h",
                 i, a_valid_o, a_ready_o, a_busy_o, a_data_o, e0.flit);
      end
    end
    @(posedge clk);
    #1 a_ready_i = 1'b1;
    wait_done_a("stall");
    check_end_a("stall", 12, 0, 0);
  endtask

  task automatic test_reset_midrun();
    int cyc;
    start_a("midrun");
    cyc = 0;
    while (!(a_ready_o === 1'b1 && a_pair_o === 16'd4) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL midrun_reach: pair=%0d ready=%b, expected WAIT of pair 4", a_pair_o, a_ready_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_busy_o, a_done_o, a_valid_o, a_ready_o, a_err_o, a_to_o, a_pair_o, a_data_o, a_sx, a_sy, a_mx, a_my} !== 88'd0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b valid=%b ready=%b pair=%0d err=%0d data=%h coords=%b, expected all 0",
               a_busy_o, a_valid_o, a_ready_o, a_pair_o, a_err_o, a_data_o, {a_sx, a_sy, a_mx, a_my});
    end
    @(negedge clk);
    fill_a();
    a_sent     = 0;
    a_done_cnt = 0;
    foreach (a_wlen[i]) a_wlen[i] = 0;
    a_start = 1'b1;
    rst_n   = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    checks++;
    if ({a_busy_o, a_pair_o, a_err_o, a_to_o} !== {1'b1, 48'd0}) begin
      errors++;
      $display("FAIL midrun_restart: busy=%b pair=%0d err=%0d to=%0d, expected busy=1 counters 0",
               a_busy_o, a_pair_o, a_err_o, a_to_o);
    end
    wait_done_a("midrun");
    check_end_a("midrun", 12, 0, 0);
  endtask

  task automatic test_noskip();
    int cyc;
    fill_b();
    b_sent  = 0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 0;
    while (b_done_o !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL noskip_done: done_o=%b after %0d cycles, expected 1", b_done_o, cyc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({b_busy_o, b_pair_o, b_err_o, b_to_o} !== {1'b0, 16'd16, 32'd0} || b_q.size() !== 0) begin
      errors++;
      $display("FAIL noskip_counts: busy=%b pair=%0d err=%0d to=%0d unsent=%0d, expected busy=0 pair=16 err=0 to=0 unsent=0",
               b_busy_o, b_pair_o, b_err_o, b_to_o, b_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_timeout();
    test_corrupt();
    test_stall();
    test_reset_midrun();
    test_noskip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mesh_traffic_sequencer.md
MESH_TRAFFIC_SEQUENCER -- requirements
Module: mesh_traffic_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, flit width.
- X_DIMENSION, 4, mesh columns.
- Y_DIMENSION, 4, mesh rows.
- X_DIM_W, X_DIMENSION>1 ? clog2(X_DIMENSION) : 1, x coordinate width.
- Y_DIM_W, Y_DIMENSION>1 ? clog2(Y_DIMENSION) : 1, y coordinate width.
- TIMEOUT, 256, max cycles in WAIT before declaring loss.
- SKIP_SELF, 1, when 1 the sequence omits pairs with source==destination.
REQ-002 Ports, one per line: name  direction  width  meaning.
- clk_i  in  1  clock.
- arstn_i  in  1  reset.
- start_i  in  1  run request, sampled in IDLE only.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at run end.
- err_cnt_o  out  16  mismatches plus timeouts, saturating.
- to_cnt_o  out  16  timeouts only, saturating.
- pair_cnt_o  out  16  pairs completed, saturating.
- data_o  out  DATA_WIDTH  flit to the mesh injection port.
- valid_o  out  1  injection valid.
- ready_i  in  1  injection ready.
- source_x_o  out  X_DIM_W  injecting node x.
- source_y_o  out  Y_DIM_W  injecting node y.
- data_i  in  DATA_WIDTH  flit from the monitored node.
- valid_i  in  1  monitored flit valid.
- ready_o  out  1  monitored-node ready.
- monitor_x_o  out  X_DIM_W  monitored node x.
- monitor_y_o  out  Y_DIM_W  monitored node y.
REQ-003 One clock, clk_i; reset arstn_i is asynchronous and active-low.

Function
REQ-004 FSM states: IDLE, SETUP, SEND, WAIT, NEXT, DONE.
REQ-005 Transitions:
- IDLE->SETUP when start_i=1.
- SETUP->SEND after exactly one cycle.
- SEND->WAIT on the cycle valid_o&&ready_i.
- WAIT->NEXT on valid_i&&ready_o, or when the timeout counter reaches TIMEOUT-1.
- NEXT->SETUP if pairs remain, else NEXT->DONE.
- DONE->IDLE after one cycle.
REQ-006 Pair order:
- Source index outer loop, destination index inner loop.
- Index = y*X_DIMENSION + x; x increments first, wraps to 0 at X_DIMENSION-1 and carries into y.
- First pair: src=(0,0) to dst=(0,0), or dst=(1,0) when SKIP_SELF=1.
- Run ends after src=dst=(X_DIMENSION-1,Y_DIMENSION-1), or after src=last, dst=second-last when SKIP_SELF=1.
REQ-007 Coordinate outputs:
- source_x_o/source_y_o = current source; monitor_x_o/monitor_y_o = current destination.
- Held constant from SETUP through NEXT.
REQ-008 Flit format driven in SEND:
- data_o[X_DIM_W-1:0] = destination x.
- Next Y_DIM_W bits = destination y.
- Remaining upper bits = pair_cnt_o, truncated or zero-extended.
REQ-009 Handshake:
- valid_o=1 only in SEND; data_o is stable while valid_o=1 and ready_i=0.
- ready_o=1 only in WAIT.
- valid_i outside WAIT is ignored.
REQ-010 Checking:
- On acceptance in WAIT, compare data_i with the flit sent for this pair.
- Mismatch: err_cnt_o +1.
- Timeout: err_cnt_o +1 and to_cnt_o +1.
- Counters saturate at 16'hFFFF.
REQ-011 Timeout counter:
- Cleared on entry to WAIT, increments each WAIT cycle.
- If arrival and timeout coincide in the same cycle, the cycle counts as an arrival.
REQ-012 pair_cnt_o increments once per NEXT cycle.
REQ-013 Counter lifetime:
- All counters clear on the IDLE->SETUP transition.
- Values hold after DONE until the next start.
REQ-014 start_i while busy_o=1 is ignored; there is no abort input.
REQ-015 SEND has no timeout: the FSM waits indefinitely for ready_i.

Reset
REQ-016 On arstn_i=0, immediately, including mid-run:
- State=IDLE.
- busy_o, done_o, valid_o, ready_o = 0.
- All counters, coordinates and data_o = 0.
REQ-017 The first start_i after reset release is honoured on the first rising edge at which arstn_i=1.

Verification
REQ-018 2x2 mesh, SKIP_SELF=1, ideal loopback (valid_i one cycle after handshake, data echoed) -> 12 pairs, err_cnt_o=0, to_cnt_o=0, pair_cnt_o=12, single done_o pulse.
REQ-019 2x2 mesh, SKIP_SELF=0 -> 16 pairs in order src0:dst0..3, src1:dst0..3, and so on; pair_cnt_o=16.
REQ-020 Never assert valid_i for pair 3, TIMEOUT=8 -> WAIT lasts exactly 8 cycles, to_cnt_o=1, err_cnt_o=1, run completes.
REQ-021 Corrupt data_i bit 0 on pair 5 -> err_cnt_o=1, to_cnt_o=0.
REQ-022 Hold ready_i=0 for 10 cycles in SEND -> valid_o and data_o stable throughout, no state change.
REQ-023 Assert arstn_i=0 during WAIT of pair 4, then restart -> all outputs 0 during reset; next run starts at pair 0 with counters 0.
